// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss/refill sequencer for the instruction cache.
// On a fetch miss it stalls the PC/F2D registers, reads the missing line
// word by word from main memory (ascending order), writes the data array,
// writes the tag on the final cycle and then releases the stall.
// Optional build macro: ICACHE_PERF_EN adds miss and stall-cycle counters.
module icache_refill_ctrl #(
    parameter  int LINE_WORDS = 4,
    parameter  int ADDR_W     = 32,
    localparam int OFS_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] pc,
    input  logic              hit,
    output logic              Mem_Stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              fill_we,
    output logic [OFS_W-1:0]  fill_idx,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [31:0]       fill_data,
    output logic              tag_we
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       perf_miss_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clears the word offset and byte offset bits to form the line base.
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFS_W-2){1'b1}}, {(OFS_W+2){1'b0}}};
    localparam logic [OFS_W-1:0]  LAST_IDX  = OFS_W'(LINE_WORDS - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   line_base_reg, line_base_next;
    logic [OFS_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   word_ofs;
    logic                miss;

    // No miss is reported while held in reset, so every output reads 0.
    assign miss     = rst_n & lookup_valid & ~hit;
    assign word_ofs = {{(ADDR_W-OFS_W-2){1'b0}}, cnt_reg, 2'b00};

    // State, line base and word counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            line_base_reg <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            line_base_reg <= line_base_next;
            cnt_reg       <= cnt_next;
        end
    end

    // Next-state and output decode; outputs default to 0 in every state.
    always_comb begin
        state_next     = state_reg;
        line_base_next = line_base_reg;
        cnt_next       = cnt_reg;
        Mem_Stall      = 1'b0;
        mem_req        = 1'b0;
        mem_addr       = '0;
        fill_we        = 1'b0;
        fill_idx       = '0;
        fill_addr      = '0;
        fill_data      = '0;
        tag_we         = 1'b0;
        case (state_reg)
            IDLE: begin
                Mem_Stall = miss;
                if (miss) begin
                    line_base_next = pc & LINE_MASK;
                    cnt_next       = '0;
                    state_next     = FILL;
                end
            end
            FILL: begin
                Mem_Stall = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = line_base_reg | word_ofs;
                fill_addr = line_base_reg;
                if (mem_ack) begin
                    fill_we   = 1'b1;
                    fill_idx  = cnt_reg;
                    fill_data = mem_rdata;
                    cnt_next  = cnt_reg + OFS_W'(1);
                    if (cnt_reg == LAST_IDX) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // Line is complete: mark it valid, refetch hits next cycle.
                Mem_Stall  = 1'b1;
                tag_we     = 1'b1;
                fill_addr  = line_base_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_miss_reg, perf_stall_reg;

    // Free-running miss and stall-cycle counters, wrapping at 32 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_miss_reg  <= '0;
            perf_stall_reg <= '0;
        end else begin
            if (state_reg == IDLE && miss) begin
                perf_miss_reg <= perf_miss_reg + 32'd1;
            end
            if (Mem_Stall) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
        end
    end

    assign perf_miss_cnt  = perf_miss_reg;
    assign perf_stall_cnt = perf_stall_reg;
`endif

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Miss/refill sequencer for the instruction cache in front of the fetch stage.
- On a fetch miss it raises Mem_Stall, which freezes the PC and the F2D pipeline register.
- It fetches the missing line word-by-word from main memory, writes the data and tag arrays, then releases the stall so the refetch hits.

Parameters:
- LINE_WORDS, 4, words per cache line; power of two, ≥2.
- ADDR_W, 32, byte-address width.
- OFS_W, $clog2(LINE_WORDS), word-index width (localparam).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- lookup_valid  in  1  fetch lookup this cycle
- pc  in  ADDR_W  fetch byte address
- hit  in  1  tag-compare result for pc (combinational from cache)
- Mem_Stall  out  1  stall to PC register and F2D register
- mem_req  out  1  word read request to main memory
- mem_addr  out  ADDR_W  word-aligned request address
- mem_ack  in  1  memory returns mem_rdata for current mem_addr this cycle
- mem_rdata  in  32  returned word
- fill_we  out  1  data-array word write enable
- fill_idx  out  OFS_W  word index within line being written
- fill_addr  out  ADDR_W  line base address (index+tag source for arrays)
- fill_data  out  32  data to write
- tag_we  out  1  tag/valid write enable for line at fill_addr

Behaviour:
- States: IDLE, FILL, DONE; 2-bit encoded state register.
- Registers: line_base (ADDR_W), cnt (OFS_W).
- Reset (async): state=IDLE, line_base=0, cnt=0.
- Outputs at reset: Mem_Stall=0, mem_req=0, mem_addr=0, fill_we=0, fill_idx=0, fill_addr=0, fill_data=0, tag_we=0.
- IDLE:
  - miss = lookup_valid & ~hit.
  - Mem_Stall = miss, combinational, same cycle as the lookup.
  - On miss: line_base <= pc with low OFS_W+2 bits cleared; cnt <= 0; next state FILL.
  - lookup_valid=0 or hit=1: stay IDLE, all outputs 0.
- FILL:
  - Mem_Stall=1; mem_req=1; mem_addr = line_base | (cnt<<2).
  - mem_req is held until mem_ack; the memory may take any number of cycles.
  - On mem_ack: fill_we=1, fill_idx=cnt, fill_data=mem_rdata (all combinational pass-through), and cnt <= cnt+1.
  - mem_ack with cnt==LINE_WORDS-1: cnt wraps to 0, next state DONE.
  - mem_ack=0: outputs except mem_req/mem_addr/Mem_Stall/fill_addr stay 0; remain in FILL.
- DONE:
  - Exactly one cycle: Mem_Stall=1, tag_we=1, mem_req=0; next state IDLE.
  - Next cycle the refetch of pc hits and the stall drops.
- fill_addr = line_base in FILL and DONE, 0 otherwise.
- Miss latency with zero-wait memory: stall asserted LINE_WORDS+2 cycles (miss cycle + LINE_WORDS fill + DONE).
- hit, pc and lookup_valid are ignored outside IDLE.
- mem_ack outside FILL is ignored.
- Flush/redirect is not an input: a refill in progress always completes. The front end owns FlushD, and the cached line remains valid.
- Reset mid-FILL: immediate return to IDLE, mem_req drops asynchronously, and no tag_we is issued. The partially written line stays invalid.
- Words are written in ascending index order; there is no critical-word-first.

Optional Feature:
- Macro ICACHE_PERF_EN.
- When defined, adds two outputs, both reset to 0 and free-running with 32-bit wrap-around:
  - perf_miss_cnt (32 bits): increments on each IDLE→FILL transition.
  - perf_stall_cnt (32 bits): increments every cycle Mem_Stall=1.
- When undefined, neither port nor register exists and behaviour is otherwise identical.

Test Plan:
- Hit path: reset, lookup_valid=1, hit=1, pc=0x100 for 10 cycles -> Mem_Stall=0, mem_req=0 throughout.
- Miss, zero-wait memory: pc=0x0000_1234, hit=0, mem_ack tied 1.
  - mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C with fill_idx 0..3 and fill_addr=0x1230.
  - tag_we pulses once at cycle 5; Mem_Stall high exactly cycles 0–5.
- Wait states: same miss, mem_ack only every 3rd cycle.
  - mem_addr is held steady between acks and fill_we fires only on ack cycles.
  - Mem_Stall high 2+3*4=14 cycles.
- Ignore stimulus during refill: toggle hit, pc and lookup_valid randomly in FILL, and pulse mem_ack during IDLE.
  - Refill address sequence is unchanged.
  - No fill_we outside FILL.
- Reset mid-FILL: deassert rst_n after 2 acked words.
  - mem_req=0 and Mem_Stall=0 immediately, no tag_we.
  - After release, a new miss at pc=0x2000 restarts at mem_addr 0x2000, fill_idx 0.
- ICACHE_PERF_EN: two back-to-back zero-wait misses -> perf_miss_cnt=2, perf_stall_cnt=12.
